mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Arbiter and sequencer for the single shared memory bus. The instruction-fetch port (IF) and the data port (MEM) both request this bus.
- Grants one requester at a time and drives the bus through an address/data handshake.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Raises per-stage stall requests, which CTRL uses to build the stall vector.
- Sits between the pipeline stages and the bus bridge. One transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; the strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held until inst_data_ok or withdrawn on flush
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetch data; valid with inst_data_ok
- inst_data_ok  out  1  one-cycle completion pulse for fetch
- data_req  in  1  load/store request; held until data_data_ok
- data_wr  in  1  1=store, 0=load
- data_wstrb  in  DATA_W/8  byte strobes for a store
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data; valid with data_data_ok
- data_data_ok  out  1  one-cycle completion pulse for load/store
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_wstrb  out  DATA_W/8  bus strobes
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  bus accepted the address phase
- bus_data_ok  in  1  bus completed the data phase
- bus_rdata  in  DATA_W  bus read data
- stallreq_for_if  out  1  stall request for the fetch stage
- stallreq_for_mem  out  1  stall request for the memory stage

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Owner register: NONE/INST/DATA.
- Reset (async, resetn=0) values:
  - state=IDLE, owner=NONE.
  - bus_req=0, bus_wr=0, bus_wstrb=0, bus_addr=0, bus_wdata=0.
  - inst_data_ok=0, data_data_ok=0, inst_rdata=0, data_rdata=0.
  - Reset in mid-transaction abandons it; no completion pulse is produced.
- IDLE:
  - data_req has priority over inst_req, because MEM holds the older instruction.
  - On grant, latch owner, wr, wstrb, addr and wdata, then go to ISSUE at the next edge.
  - An inst grant always latches wr=0 and wstrb=0.
  - With no request, stay in IDLE.
- ISSUE:
  - bus_req=1 and the bus_* fields are driven from the latched registers, stable until accepted.
  - bus_addr_ok=1 with bus_data_ok=0: go to WAIT, bus_req=0.
  - bus_addr_ok=1 with bus_data_ok=1 in the same cycle: complete directly and go to IDLE.
- WAIT:
  - bus_req=0.
  - On bus_data_ok, complete and go to IDLE.
- Completion:
  - The registered owner pulses its *_data_ok for exactly one cycle, the cycle after bus_data_ok.
  - *_rdata is registered from bus_rdata and holds until the next completion for that port.
  - Writes still pulse data_data_ok; data_rdata is unchanged on a write.
- Flush/withdraw: if the owner's req is 0 at the bus_data_ok cycle, the bus transaction still finishes, but no pulse is produced and the data is discarded.
- Grant timing:
  - No grant in the cycle a completion pulse is issued.
  - The next grant happens at the earliest one cycle after returning to IDLE.
  - Minimum turnaround is 3 cycles per transaction.
- Stall requests (combinational):
  - stallreq_for_if = inst_req & ~inst_data_ok
  - stallreq_for_mem = data_req & ~data_data_ok
- Bus signals with bus_req=0 are don't-care but hold their last values.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register (reset value INST) is kept.
  - When both requests are pending in IDLE, grant the port that did not win the last grant.
  - A single pending request is granted normally.
- Undefined: fixed data-over-inst priority as above; no last_grant register.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: inst_req=1, addr=0x0000_0100; assert resetn=0 while in WAIT.
  - Required: bus_req=0 and all outputs 0 immediately; no inst_data_ok after release.
- Single fetch:
  - Stimulus: inst_req=1, addr=0xBFC0_0000; bus_addr_ok at cycle 2, bus_data_ok with rdata=0x2408_0001 at cycle 4.
  - Required: bus_addr=0xBFC0_0000 and bus_wr=0 during ISSUE; inst_data_ok pulses at cycle 5 with inst_rdata=0x2408_0001; stallreq_for_if is 1 until then.
- Simultaneous requests, macro off:
  - Stimulus: data_req (load 0x8000_0010) and inst_req asserted together.
  - Required: data granted first; inst is issued only after data_data_ok; stallreq_for_if stays 1 throughout.
- Store:
  - Stimulus: data_wr=1, wstrb=4'b0011, wdata=0x1234_ABCD, addr=0x8000_0020; addr_ok and data_ok in the same cycle.
  - Required: the bus carries exactly these values; data_data_ok pulses next cycle; data_rdata is unchanged.
- Flush:
  - Stimulus: inst_req drops while in WAIT.
  - Required: the transaction waits for bus_data_ok; no inst_data_ok; FSM returns to IDLE.
- Round-robin, macro on:
  - Stimulus: both requests held continuously for 4 transactions.
  - Required: grant order DATA, INST, DATA, INST.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter: grants IF or MEM, sequences the bus handshake.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both ports request.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_data_ok,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_data_ok,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stallreq_for_if,
    output logic                stallreq_for_mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_t;

    state_t state;
    owner_t owner;
    // Set on the cycle we return to IDLE so no grant overlaps a completion.
    logic   cool;
    logic   pick_data;
    logic   pick_inst;
    logic   done;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    // Alternate between ports when both are pending; otherwise serve the one.
    always_comb begin
        pick_data = 1'b0;
        pick_inst = 1'b0;
        unique case (1'b1)
            (data_req & inst_req): begin
                pick_data = (last_grant == OWN_INST);
                pick_inst = (last_grant != OWN_INST);
            end
            data_req: pick_data = 1'b1;
            inst_req: pick_inst = 1'b1;
            default: ;
        endcase
    end
`else
    // MEM holds the older instruction, so it always wins a tie.
    always_comb begin
        pick_data = data_req;
        pick_inst = inst_req & ~data_req;
    end
`endif

    assign done = bus_data_ok &
                  (((state == S_ISSUE) & bus_addr_ok) | (state == S_WAIT));

    // Grant, address phase and data phase sequencing with latched bus fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            owner     <= OWN_NONE;
            cool      <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= OWN_INST;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cool) begin
                        cool <= 1'b0;
                    end else if (pick_data) begin
                        owner     <= OWN_DATA;
                        bus_req   <= 1'b1;
                        bus_wr    <= data_wr;
                        bus_wstrb <= data_wstrb;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        state     <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= OWN_DATA;
`endif
                    end else if (pick_inst) begin
                        owner     <= OWN_INST;
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_wstrb <= '0;
                        bus_addr  <= inst_addr;
                        state     <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= OWN_INST;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= bus_data_ok ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (done) begin
                owner <= OWN_NONE;
                cool  <= 1'b1;
            end
        end
    end

    // Completion pulse and read data capture for the owner, if still asking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            if (done && owner == OWN_INST && inst_req) begin
                inst_data_ok <= 1'b1;
                inst_rdata   <= bus_rdata;
            end
            if (done && owner == OWN_DATA && data_req) begin
                data_data_ok <= 1'b1;
                if (!bus_wr) begin
                    data_rdata <= bus_rdata;
                end
            end
        end
    end

    assign stallreq_for_if  = inst_req & ~inst_data_ok;
    assign stallreq_for_mem = data_req & ~data_data_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction model plus directed scenarios.
// Bus slave responds with programmable address/data latencies.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata;
    logic        stallreq_for_if;
    logic        stallreq_for_mem;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_rdata      (inst_rdata),
        .inst_data_ok    (inst_data_ok),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_wstrb      (data_wstrb),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_rdata      (data_rdata),
        .data_data_ok    (data_data_ok),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_wstrb       (bus_wstrb),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata),
        .stallreq_for_if (stallreq_for_if),
        .stallreq_for_mem(stallreq_for_mem)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Bus slave: read data is the address xor a per-test key
    int          sl_alat = 0;
    int          sl_dlat = 0;
    logic [31:0] sl_rdata = '0;
    int          ca = 0;
    int          cd = 0;
    bit          pend = 1'b0;

    assign bus_rdata = sl_rdata ^ bus_addr;

    always begin
        @(posedge clk);
        #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (!resetn) begin
            pend = 1'b0;
            ca = 0;
            cd = 0;
        end else if (pend) begin
            cd++;
            if (cd >= sl_dlat) begin
                bus_data_ok = 1'b1;
                pend = 1'b0;
            end
        end else if (bus_req) begin
            if (ca >= sl_alat) begin
                bus_addr_ok = 1'b1;
                ca = 0;
                if (sl_dlat == 0) bus_data_ok = 1'b1;
                else begin
                    pend = 1'b1;
                    cd = 0;
                end
            end else begin
                ca++;
            end
        end
    end

    // Transaction-level model: one job in flight, one quiet cycle after it
    bit          m_busy, m_acc, m_cool, m_own_data, m_last_data, m_take;
    logic        exp_iok, exp_dok, exp_wr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_addr, exp_wdata, exp_irdata, exp_drdata;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_acc = 0; m_cool = 0;
            m_own_data = 0; m_last_data = 0;
            exp_iok = 0; exp_dok = 0; exp_wr = 0; exp_wstrb = 0;
            exp_addr = 0; exp_wdata = 0; exp_irdata = 0; exp_drdata = 0;
        end else begin
            exp_iok = 0;
            exp_dok = 0;
            if (!m_busy) begin
                if (m_cool) m_cool = 0;
                else if (data_req || inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_take = data_req && (!inst_req || !m_last_data);
`else
                    m_take = data_req;
`endif
                    m_busy = 1; m_acc = 0;
                    m_own_data = m_take;
                    m_last_data = m_take;
                    if (m_take) begin
                        exp_wr = data_wr; exp_wstrb = data_wstrb;
                        exp_addr = data_addr; exp_wdata = data_wdata;
                    end else begin
                        exp_wr = 0; exp_wstrb = 0; exp_addr = inst_addr;
                    end
                end
            end else if (bus_data_ok && (m_acc || bus_addr_ok)) begin
                m_busy = 0;
                m_cool = 1;
                if (m_own_data && data_req) begin
                    exp_dok = 1;
                    if (!exp_wr) exp_drdata = sl_rdata ^ exp_addr;
                end
                if (!m_own_data && inst_req) begin
                    exp_iok = 1;
                    exp_irdata = sl_rdata ^ exp_addr;
                end
            end else if (bus_addr_ok) begin
                m_acc = 1;
            end
        end
    end

    // Per-cycle compare against the model, plus grant-order recorder
    int          n_iok = 0;
    logic [31:0] q[$];
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        chk("bus_req", bus_req, m_busy && !m_acc);
        chk("inst_ok", inst_data_ok, exp_iok);
        chk("data_ok", data_data_ok, exp_dok);
        chk("inst_rdata", inst_rdata, exp_irdata);
        chk("data_rdata", data_rdata, exp_drdata);
        chk("stall_if", stallreq_for_if, inst_req & ~exp_iok);
        chk("stall_mem", stallreq_for_mem, data_req & ~exp_dok);
        if (bus_req) begin
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_wr", bus_wr, exp_wr);
            chk("bus_wstrb", bus_wstrb, exp_wstrb);
            if (exp_wr) chk("bus_wdata", bus_wdata, exp_wdata);
        end
        if (inst_data_ok) n_iok++;
        if (bus_req && !prev_req) q.push_back(bus_addr);
        prev_req = bus_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_inst(input logic [31:0] a, input bit keep);
        bit got = 0;
        inst_addr = a;
        inst_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (inst_data_ok) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("inst_timeout", 0, 1);
        tick();
        if (!keep) inst_req = 1'b0;
    endtask

    task automatic do_data(input bit wr, input logic [3:0] st,
                           input logic [31:0] wd, input logic [31:0] a,
                           input bit keep);
        bit got = 0;
        data_wr = wr;
        data_wstrb = st;
        data_wdata = wd;
        data_addr = a;
        data_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (data_data_ok) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("data_timeout", 0, 1);
        tick();
        if (!keep) data_req = 1'b0;
    endtask

    int cnt;

    initial begin
        #1 resetn = 1'b0;
        tick();
        tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_inst_ok", inst_data_ok, 0);
        resetn = 1'b1;
        tick();

        // Single fetch, cycle-accurate
        sl_alat = 1; sl_dlat = 2; sl_rdata = 32'h9BC8_0001;
        inst_addr = 32'hBFC0_0000;
        inst_req = 1'b1;
        #1 chk("sf_stall_c0", stallreq_for_if, 1);
        tick();
        chk("sf_req_c1", bus_req, 1);
        chk("sf_addr_c1", bus_addr, 32'hBFC0_0000);
        chk("sf_wr_c1", bus_wr, 0);
        tick();
        chk("sf_req_c2", bus_req, 1);
        tick();
        chk("sf_req_c3", bus_req, 0);
        tick();
        chk("sf_ok_c4", inst_data_ok, 0);
        chk("sf_stall_c4", stallreq_for_if, 1);
        tick();
        chk("sf_ok_c5", inst_data_ok, 1);
        chk("sf_rdata_c5", inst_rdata, 32'h2408_0001);
        chk("sf_stall_c5", stallreq_for_if, 0);
        tick();
        inst_req = 1'b0;
        chk("sf_ok_c6", inst_data_ok, 0);
        tick();

        // Reset while waiting for read data
        sl_alat = 0; sl_dlat = 20;
        inst_addr = 32'h0000_0100;
        inst_req = 1'b1;
        tick();
        tick();
        chk("rw_in_wait", bus_req, 0);
        tick();
        resetn = 1'b0;
        inst_req = 1'b0;
        #1;
        chk("rw_bus_req", bus_req, 0);
        chk("rw_bus_addr", bus_addr, 0);
        chk("rw_inst_ok", inst_data_ok, 0);
        chk("rw_inst_rdata", inst_rdata, 0);
        tick();
        tick();
        resetn = 1'b1;
        cnt = n_iok;
        repeat (25) tick();
        chk("rw_no_pulse", n_iok - cnt, 0);

        // Simultaneous load and fetch: load first
        sl_alat = 1; sl_dlat = 1; sl_rdata = 32'hCAFE_0001;
        q.delete();
        fork
            do_data(1'b0, 4'h0, 32'h0, 32'h8000_0010, 1'b0);
            do_inst(32'h0000_1000, 1'b0);
        join
        chk("sim_n", q.size(), 2);
        if (q.size() == 2) begin
            chk("sim_first", q[0], 32'h8000_0010);
            chk("sim_second", q[1], 32'h0000_1000);
        end
        chk("sim_drdata", data_rdata, 32'h4AFE_0011);
        chk("sim_irdata", inst_rdata, 32'hCAFE_1001);
        tick();

        // Store with address and data accepted together
        sl_alat = 0; sl_dlat = 0;
        data_wr = 1'b1;
        data_wstrb = 4'b0011;
        data_wdata = 32'h1234_ABCD;
        data_addr = 32'h8000_0020;
        data_req = 1'b1;
        tick();
        chk("st_req", bus_req, 1);
        chk("st_wr", bus_wr, 1);
        chk("st_strb", bus_wstrb, 4'b0011);
        chk("st_addr", bus_addr, 32'h8000_0020);
        chk("st_wdata", bus_wdata, 32'h1234_ABCD);
        tick();
        chk("st_ok", data_data_ok, 1);
        chk("st_rdata", data_rdata, 32'h4AFE_0011);
        tick();
        data_req = 1'b0;
        data_wr = 1'b0;
        data_wstrb = '0;
        chk("st_ok_once", data_data_ok, 0);
        tick();

        // Flush: fetch withdrawn in WAIT, then a load must still get through
        sl_alat = 0; sl_dlat = 6;
        cnt = n_iok;
        inst_addr = 32'h0000_3000;
        inst_req = 1'b1;
        tick();
        tick();
        chk("fl_in_wait", bus_req, 0);
        inst_req = 1'b0;
        do_data(1'b0, 4'h0, 32'h0, 32'h8000_0040, 1'b0);
        chk("fl_no_pulse", n_iok - cnt, 0);
        chk("fl_drdata", data_rdata, 32'h4AFE_0041);
        tick();

        // Both ports held for four back-to-back transactions
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        sl_alat = 0; sl_dlat = 1;
        q.delete();
        fork
            begin
                do_data(1'b0, 4'h0, 32'h0, 32'h8000_0100, 1'b1);
                do_data(1'b0, 4'h0, 32'h0, 32'h8000_0104, 1'b0);
            end
            begin
                do_inst(32'h0000_2000, 1'b1);
                do_inst(32'h0000_2004, 1'b0);
            end
        join
        chk("bb_n", q.size(), 4);
        if (q.size() == 4) begin
            chk("bb_g0", q[0], 32'h8000_0100);
`ifdef ARB_ROUND_ROBIN_EN
            chk("bb_g1", q[1], 32'h0000_2000);
            chk("bb_g2", q[2], 32'h8000_0104);
`else
            chk("bb_g1", q[1], 32'h8000_0104);
            chk("bb_g2", q[2], 32'h0000_2000);
`endif
            chk("bb_g3", q[3], 32'h0000_2004);
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
